// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU operand sequencer: opcodes, FSM encoding and default widths.
// Imported by the sequencer top and its register file.
package alu_op_sequencer_pkg;

    localparam int SEQ_DATA_W = 16;
    localparam int SEQ_REG_AW = 3;
    localparam int SEQ_CTRL_W = 3;

    localparam logic [SEQ_CTRL_W-1:0] OP_ADD = 3'b000;
    localparam logic [SEQ_CTRL_W-1:0] OP_SUB = 3'b001;
    localparam logic [SEQ_CTRL_W-1:0] OP_NOT = 3'b010;
    localparam logic [SEQ_CTRL_W-1:0] OP_SHL = 3'b011;
    localparam logic [SEQ_CTRL_W-1:0] OP_SHR = 3'b100;
    localparam logic [SEQ_CTRL_W-1:0] OP_AND = 3'b101;
    localparam logic [SEQ_CTRL_W-1:0] OP_OR  = 3'b110;
    localparam logic [SEQ_CTRL_W-1:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2
    } seq_state_t;

    // A NOP still runs the full three-cycle sequence but never touches the register file.
    function automatic logic op_writes_back(input logic [SEQ_CTRL_W-1:0] op);
        return (op != OP_NOP);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_regfile.sv
// Operand register file for the ALU sequencer: async-cleared flops, one write port,
// three combinational read ports (operand A, operand B, host readback).
module alu_regfile
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W,
    parameter int REG_AW = SEQ_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    input  logic [REG_AW-1:0] i_raddr_h,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [DATA_W-1:0] o_rdata_h
);

    localparam int NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
    assign o_rdata_h = r_mem[i_raddr_h];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of the 16-bit ALU: accepts a command, fetches operands,
// drives the ALU for one cycle, then writes the result back and pulses done_valid.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W,
    parameter int REG_AW = SEQ_REG_AW,
    parameter int CTRL_W = SEQ_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CTRL_W-1:0] cmd_op,
    input  logic [REG_AW-1:0] cmd_dst,
    input  logic [REG_AW-1:0] cmd_src_a,
    input  logic [REG_AW-1:0] cmd_src_b,
    input  logic              cmd_imm_sel,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_z,
    input  logic              alu_g,
    output logic              done_valid,
    output logic [DATA_W-1:0] done_result,
    output logic              done_z,
    output logic              done_g,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;

    logic [CTRL_W-1:0] r_op;
    logic [REG_AW-1:0] r_dst;
    logic [REG_AW-1:0] r_src_a;
    logic [REG_AW-1:0] r_src_b;
    logic              r_imm_sel;
    logic [DATA_W-1:0] r_imm;

    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [CTRL_W-1:0] r_alu_control;
    logic              r_done_valid;
    logic [DATA_W-1:0] r_done_result;
    logic              r_done_z;
    logic              r_done_g;

    logic              w_accept;
    logic              w_load_ops;
    logic              w_commit;
    logic              w_writeback;
    logic              w_rf_we;
    logic [REG_AW-1:0] w_rf_waddr;
    logic [DATA_W-1:0] w_rf_wdata;
    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;

    assign cmd_ready = (r_state == ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The single write port belongs to the host in IDLE and to writeback in EXEC.
    always_comb begin
        w_state_nxt = r_state;
        w_load_ops  = 1'b0;
        w_commit    = 1'b0;
        w_writeback = 1'b0;
        w_rf_we     = 1'b0;
        w_rf_waddr  = wr_addr;
        w_rf_wdata  = wr_data;
        case (r_state)
            ST_IDLE: begin
                w_rf_we = wr_en;
                if (cmd_valid) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_load_ops  = 1'b1;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_commit = 1'b1;
                if (op_writes_back(r_op)) begin
                    w_writeback = 1'b1;
                    w_rf_we     = 1'b1;
                    w_rf_waddr  = r_dst;
                    w_rf_wdata  = alu_result;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_dst     <= '0;
            r_src_a   <= '0;
            r_src_b   <= '0;
            r_imm_sel <= 1'b0;
            r_imm     <= '0;
        end else if (w_accept) begin
            r_op      <= cmd_op;
            r_dst     <= cmd_dst;
            r_src_a   <= cmd_src_a;
            r_src_b   <= cmd_src_b;
            r_imm_sel <= cmd_imm_sel;
            r_imm     <= cmd_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= '0;
        end else if (w_load_ops) begin
            r_alu_a       <= w_rf_a;
            r_alu_b       <= r_imm_sel ? r_imm : w_rf_b;
            r_alu_control <= r_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_valid  <= 1'b0;
            r_done_result <= '0;
            r_done_z      <= 1'b0;
            r_done_g      <= 1'b0;
        end else begin
            r_done_valid <= w_commit;
            if (w_writeback) begin
                r_done_result <= alu_result;
                r_done_z      <= alu_z;
                r_done_g      <= alu_g;
            end
        end
    end

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_rf_we),
        .i_waddr   (w_rf_waddr),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (r_src_a),
        .i_raddr_b (r_src_b),
        .i_raddr_h (rd_addr),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b),
        .o_rdata_h (rd_data)
    );

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_control;
    assign done_valid  = r_done_valid;
    assign done_result = r_done_result;
    assign done_z      = r_done_z;
    assign done_g      = r_done_g;

endmodule
